hpdcache_mshr_ctrl: RTL
=======================

Name: hpdcache_mshr_ctrl

Overview:
Sequencer and arbiter in front of the HPDcache MSHR. It shares the MSHR's single port between two requesters:
- miss requests from the cache pipeline, run as a check then an optional allocate;
- refill acknowledges from the memory-response path, run as an ack, a one-cycle read, then a buffered info hand-off.

It guarantees the MSHR rule "ack never concurrent with check/alloc" and bounds miss starvation.

Parameters:
NlineWidth, 34, cache-line number width
SetWidth, 7, cache set index width (low bits of nline)
TagWidth, 27, tag width (NlineWidth-SetWidth)
MshrSetWidth, 2, MSHR set index width (>=1)
MshrWayWidth, 2, MSHR way index width (>=1)
TidWidth, 6, request transaction id width
SidWidth, 3, request source id width
WordWidth, 3, word index width
WayWidth, 2, cache way index width
StarveMax, 4, max consecutive ack grants while a miss waits (>=1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
miss_valid_i  in  1  miss request valid
miss_ready_o  out  1  miss request accepted
miss_nline_i  in  NlineWidth  line number
miss_tid_i / miss_sid_i / miss_word_i / miss_victim_way_i  in  Tid/Sid/Word/WayWidth  request metadata
miss_need_rsp_i / miss_is_prefetch_i / miss_wback_i  in  1 each  request flags
miss_rsp_valid_o  out  1  one-cycle result pulse
miss_rsp_hit_o / miss_rsp_full_o  out  1 each  line already pending / no free way
miss_rsp_id_o  out  MshrWayWidth+MshrSetWidth  allocated slot {way,set}
refill_valid_i  in  1  ack request valid
refill_ready_o  out  1  ack request accepted
refill_id_i  in  MshrWayWidth+MshrSetWidth  slot {way,set} to release
info_valid_o  out  1  ack info buffered
info_ready_i  in  1  consumer takes info
info_tid_o / info_sid_o / info_set_o / info_tag_o / info_way_o / info_word_o  out  field widths  entry contents
info_need_rsp_o / info_is_prefetch_o / info_wback_o  out  1 each  entry flags
mshr_check_o, mshr_check_set_o (SetWidth), mshr_check_tag_o (TagWidth)  out  check interface
mshr_hit_i, mshr_alloc_full_i  in  1 each  check results
mshr_alloc_way_i  in  MshrWayWidth  free way chosen by MSHR
mshr_alloc_o, mshr_alloc_cs_o  out  1 each; plus mshr_alloc_* fields mirroring latched miss request
mshr_ack_o, mshr_ack_cs_o  out  1 each; mshr_ack_set_o / mshr_ack_way_o  out  slot
mshr_ack_*_i  in  ack read data (tid, sid, set, way, tag, word, need_rsp, is_prefetch, wback)

Behaviour:
- FSM states: IDLE, CHECK, ACK_RD. Reset: IDLE, all outputs 0, info buffer empty, starvation counter 0.
- IDLE arbitration:
  - Ack eligible when refill_valid_i and (info buffer empty or info_ready_i this cycle).
  - Ack wins unless miss_valid_i and starve_cnt==StarveMax; then miss wins.
  - starve_cnt increments on each ack grant while miss_valid_i; clears on miss grant or when miss_valid_i is low.
- Miss grant (IDLE, cycle t):
  - miss_ready_o=1; mshr_check_o=1 with check_set=nline[SetWidth-1:0].
  - Latch request; go CHECK.
- CHECK (t+1):
  - Drive mshr_check_tag_o from latch.
  - If !hit && !alloc_full: mshr_alloc_o=mshr_alloc_cs_o=1, fields from latch.
  - Register result: at t+2 miss_rsp_valid_o=1 for one cycle, with hit/full flags and id={mshr_alloc_way_i, nline[MshrSetWidth-1:0]} (id valid only when neither flag set).
  - hit has precedence over full.
  - Return to IDLE; a new grant is allowed in the same cycle as the rsp pulse.
- Ack grant (IDLE, t):
  - refill_ready_o=1; mshr_ack_o=mshr_ack_cs_o=1 with slot fields.
  - No check/alloc asserted. Go ACK_RD.
- ACK_RD (t+1):
  - Capture mshr_ack_*_i into info buffer; info_valid_o=1 from t+2 until handshake.
  - No MSHR command this cycle. Go IDLE.
- Info buffer: one entry; stays valid while info_ready_i low. Drain and refill may happen in the same cycle (back-to-back acks every 2 cycles).
- ready outputs are asserted only in IDLE and never together.
- Mid-operation reset: abandon in-flight op; drop buffer and pending pulse.

Optional Feature:
HPDCACHE_MSHR_CTRL_PERF_EN:
- When defined, adds outputs perf_hit_o, perf_full_o, perf_alloc_o and perf_ack_o: 32-bit saturating counters, reset 0, each incremented on the matching event.
- When undefined, the ports and counters are absent.

Decomposition:
- Shared hpdcache_pkg gets mshr_ctrl_state_e (IDLE/CHECK/ACK_RD) and an mshr_ack_info_t packed struct.
- One natural sub-module: hpdcache_mshr_ctrl_infobuf, the single-entry valid/ready buffer.

Test Plan:
- Miss to empty MSHR, nline=0x155: check at t, alloc at t+1 with set bits 01; rsp at t+2 with hit=0, full=0, id={way0,01}.
- Same nline again with mshr_hit_i=1 -> no alloc; rsp hit=1.
- mshr_alloc_full_i=1, hit=0 -> rsp full=1, mshr_alloc_o never asserted.
- refill_valid_i and miss_valid_i held high, StarveMax=4 -> 4 ack grants, then a miss grant; ack never overlaps check/alloc.
- info_ready_i low after one ack -> second refill stalls (refill_ready_o=0); raise info_ready_i -> same-cycle drain and accept.
- Reset asserted in CHECK -> outputs 0 immediately, FSM IDLE, no rsp pulse.

Source files
------------

// File: rtl/hpdcache_pkg.sv
// Shared HPDcache types used by the MSHR controller: sequencer state encoding
// and the packed record held by the acknowledge info buffer.
package hpdcache_pkg;

    // Default field widths; the controller's parameters default to these so the
    // info record and the port widths stay aligned. Override them together.
    localparam int unsigned MshrCtrlTidWidth  = 6;
    localparam int unsigned MshrCtrlSidWidth  = 3;
    localparam int unsigned MshrCtrlSetWidth  = 7;
    localparam int unsigned MshrCtrlTagWidth  = 27;
    localparam int unsigned MshrCtrlWayWidth  = 2;
    localparam int unsigned MshrCtrlWordWidth = 3;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StCheck = 2'd1,
        StAckRd = 2'd2
    } mshr_ctrl_state_e;

    typedef struct packed {
        logic [MshrCtrlTidWidth-1:0]  tid;
        logic [MshrCtrlSidWidth-1:0]  sid;
        logic [MshrCtrlSetWidth-1:0]  set;
        logic [MshrCtrlWayWidth-1:0]  way;
        logic [MshrCtrlTagWidth-1:0]  tag;
        logic [MshrCtrlWordWidth-1:0] word;
        logic                         need_rsp;
        logic                         is_prefetch;
        logic                         wback;
    } mshr_ack_info_t;

endpackage

// File: rtl/hpdcache_mshr_ctrl_infobuf.sv
// Single-entry valid/ready holding buffer for MSHR acknowledge info.
// A push always wins over a drain in the same cycle; the controller only
// pushes once the previous entry has left.
module hpdcache_mshr_ctrl_infobuf
    import hpdcache_pkg::*;
#(
    parameter type info_t = mshr_ack_info_t
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  push_i,
    input  info_t push_data_i,
    output logic  valid_o,
    input  logic  ready_i,
    output info_t data_o
);

    logic  valid_q, valid_d;
    info_t data_q;

    // Occupancy: set on push, cleared on handshake.
    always_comb begin
        valid_d = valid_q;
        if (push_i) begin
            valid_d = 1'b1;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Entry storage, cleared on reset so the outputs read as zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            if (push_i) begin
                data_q <= push_data_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/hpdcache_mshr_ctrl.sv
// Sequencer/arbiter in front of the HPDcache MSHR single port. Misses run as
// check then optional allocate; refill acknowledges run as ack, one read cycle,
// then a buffered info hand-off. Acks never overlap check/alloc and a waiting
// miss is granted after at most StarveMax consecutive ack grants.
// Optional build macro: HPDCACHE_MSHR_CTRL_PERF_EN adds saturating event counters.
module hpdcache_mshr_ctrl
    import hpdcache_pkg::*;
#(
    parameter int unsigned NlineWidth   = 34,
    parameter int unsigned SetWidth     = MshrCtrlSetWidth,
    parameter int unsigned TagWidth     = NlineWidth - SetWidth,
    parameter int unsigned MshrSetWidth = 2,
    parameter int unsigned MshrWayWidth = 2,
    parameter int unsigned TidWidth     = MshrCtrlTidWidth,
    parameter int unsigned SidWidth     = MshrCtrlSidWidth,
    parameter int unsigned WordWidth    = MshrCtrlWordWidth,
    parameter int unsigned WayWidth     = MshrCtrlWayWidth,
    parameter int unsigned StarveMax    = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    // miss requests
    input  logic                             miss_valid_i,
    output logic                             miss_ready_o,
    input  logic [NlineWidth-1:0]            miss_nline_i,
    input  logic [TidWidth-1:0]              miss_tid_i,
    input  logic [SidWidth-1:0]              miss_sid_i,
    input  logic [WordWidth-1:0]             miss_word_i,
    input  logic [WayWidth-1:0]              miss_victim_way_i,
    input  logic                             miss_need_rsp_i,
    input  logic                             miss_is_prefetch_i,
    input  logic                             miss_wback_i,
    output logic                             miss_rsp_valid_o,
    output logic                             miss_rsp_hit_o,
    output logic                             miss_rsp_full_o,
    output logic [MshrWayWidth+MshrSetWidth-1:0] miss_rsp_id_o,
    // refill acknowledges
    input  logic                             refill_valid_i,
    output logic                             refill_ready_o,
    input  logic [MshrWayWidth+MshrSetWidth-1:0] refill_id_i,
    // acknowledge info hand-off
    output logic                             info_valid_o,
    input  logic                             info_ready_i,
    output logic [TidWidth-1:0]              info_tid_o,
    output logic [SidWidth-1:0]              info_sid_o,
    output logic [SetWidth-1:0]              info_set_o,
    output logic [TagWidth-1:0]              info_tag_o,
    output logic [WayWidth-1:0]              info_way_o,
    output logic [WordWidth-1:0]             info_word_o,
    output logic                             info_need_rsp_o,
    output logic                             info_is_prefetch_o,
    output logic                             info_wback_o,
    // MSHR check
    output logic                             mshr_check_o,
    output logic [SetWidth-1:0]              mshr_check_set_o,
    output logic [TagWidth-1:0]              mshr_check_tag_o,
    input  logic                             mshr_hit_i,
    input  logic                             mshr_alloc_full_i,
    input  logic [MshrWayWidth-1:0]          mshr_alloc_way_i,
    // MSHR allocate
    output logic                             mshr_alloc_o,
    output logic                             mshr_alloc_cs_o,
    output logic [NlineWidth-1:0]            mshr_alloc_nline_o,
    output logic [TidWidth-1:0]              mshr_alloc_tid_o,
    output logic [SidWidth-1:0]              mshr_alloc_sid_o,
    output logic [WordWidth-1:0]             mshr_alloc_word_o,
    output logic [WayWidth-1:0]              mshr_alloc_victim_way_o,
    output logic                             mshr_alloc_need_rsp_o,
    output logic                             mshr_alloc_is_prefetch_o,
    output logic                             mshr_alloc_wback_o,
    // MSHR acknowledge
    output logic                             mshr_ack_o,
    output logic                             mshr_ack_cs_o,
    output logic [MshrSetWidth-1:0]          mshr_ack_set_o,
    output logic [MshrWayWidth-1:0]          mshr_ack_way_o,
    input  logic [TidWidth-1:0]              mshr_ack_tid_i,
    input  logic [SidWidth-1:0]              mshr_ack_sid_i,
    input  logic [SetWidth-1:0]              mshr_ack_set_i,
    input  logic [WayWidth-1:0]              mshr_ack_way_i,
    input  logic [TagWidth-1:0]              mshr_ack_tag_i,
    input  logic [WordWidth-1:0]             mshr_ack_word_i,
    input  logic                             mshr_ack_need_rsp_i,
    input  logic                             mshr_ack_is_prefetch_i,
    input  logic                             mshr_ack_wback_i
`ifdef HPDCACHE_MSHR_CTRL_PERF_EN
    ,
    output logic [31:0]                      perf_hit_o,
    output logic [31:0]                      perf_full_o,
    output logic [31:0]                      perf_alloc_o,
    output logic [31:0]                      perf_ack_o
`endif
);

    localparam int unsigned IdWidth        = MshrWayWidth + MshrSetWidth;
    localparam int unsigned StarveCntWidth = $clog2(StarveMax + 1);

    mshr_ctrl_state_e          state_q, state_d;
    logic [StarveCntWidth-1:0] starve_cnt_q, starve_cnt_d;

    logic ack_eligible, miss_prio, grant_ack, grant_miss;
    logic in_check, chk_hit, chk_full, do_alloc, info_push;

    // Latched miss request
    logic [NlineWidth-1:0] req_nline_q;
    logic [TidWidth-1:0]   req_tid_q;
    logic [SidWidth-1:0]   req_sid_q;
    logic [WordWidth-1:0]  req_word_q;
    logic [WayWidth-1:0]   req_victim_way_q;
    logic                  req_need_rsp_q, req_is_prefetch_q, req_wback_q;

    // Registered miss result
    logic               rsp_valid_q, rsp_hit_q, rsp_full_q;
    logic [IdWidth-1:0] rsp_id_q;

    mshr_ack_info_t ack_info, info_q;

    // Idle-state arbitration between refill acks and misses.
    always_comb begin
        ack_eligible = refill_valid_i && (!info_valid_o || info_ready_i);
        miss_prio    = miss_valid_i && (starve_cnt_q == StarveCntWidth'(StarveMax));
        grant_ack    = (state_q == StIdle) && ack_eligible && !miss_prio;
        grant_miss   = (state_q == StIdle) && miss_valid_i && !grant_ack;
        in_check     = (state_q == StCheck);
        // A hit masks a simultaneous full indication.
        chk_hit      = in_check && mshr_hit_i;
        chk_full     = in_check && !mshr_hit_i && mshr_alloc_full_i;
        do_alloc     = in_check && !mshr_hit_i && !mshr_alloc_full_i;
        info_push    = (state_q == StAckRd);
    end

    // Count ack grants that bypass a waiting miss.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!miss_valid_i || grant_miss) begin
            starve_cnt_d = '0;
        end else if (grant_ack && (starve_cnt_q < StarveCntWidth'(StarveMax))) begin
            starve_cnt_d = starve_cnt_q + StarveCntWidth'(1);
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (grant_miss) begin
                    state_d = StCheck;
                end else if (grant_ack) begin
                    state_d = StAckRd;
                end
            end
            StCheck: state_d = StIdle;
            StAckRd: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM state and starvation counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // FSM outputs: MSHR port commands and requester handshakes.
    always_comb begin
        miss_ready_o             = 1'b0;
        refill_ready_o           = 1'b0;
        mshr_check_o             = 1'b0;
        mshr_check_set_o         = '0;
        mshr_check_tag_o         = '0;
        mshr_alloc_o             = 1'b0;
        mshr_alloc_cs_o          = 1'b0;
        mshr_alloc_nline_o       = '0;
        mshr_alloc_tid_o         = '0;
        mshr_alloc_sid_o         = '0;
        mshr_alloc_word_o        = '0;
        mshr_alloc_victim_way_o  = '0;
        mshr_alloc_need_rsp_o    = 1'b0;
        mshr_alloc_is_prefetch_o = 1'b0;
        mshr_alloc_wback_o       = 1'b0;
        mshr_ack_o               = 1'b0;
        mshr_ack_cs_o            = 1'b0;
        mshr_ack_set_o           = '0;
        mshr_ack_way_o           = '0;
        unique case (state_q)
            StIdle: begin
                if (grant_miss) begin
                    miss_ready_o     = 1'b1;
                    mshr_check_o     = 1'b1;
                    mshr_check_set_o = miss_nline_i[SetWidth-1:0];
                end
                if (grant_ack) begin
                    refill_ready_o = 1'b1;
                    mshr_ack_o     = 1'b1;
                    mshr_ack_cs_o  = 1'b1;
                    mshr_ack_set_o = refill_id_i[MshrSetWidth-1:0];
                    mshr_ack_way_o = refill_id_i[IdWidth-1:MshrSetWidth];
                end
            end
            StCheck: begin
                mshr_check_tag_o = req_nline_q[NlineWidth-1:SetWidth];
                if (do_alloc) begin
                    mshr_alloc_o             = 1'b1;
                    mshr_alloc_cs_o          = 1'b1;
                    mshr_alloc_nline_o       = req_nline_q;
                    mshr_alloc_tid_o         = req_tid_q;
                    mshr_alloc_sid_o         = req_sid_q;
                    mshr_alloc_word_o        = req_word_q;
                    mshr_alloc_victim_way_o  = req_victim_way_q;
                    mshr_alloc_need_rsp_o    = req_need_rsp_q;
                    mshr_alloc_is_prefetch_o = req_is_prefetch_q;
                    mshr_alloc_wback_o       = req_wback_q;
                end
            end
            default: ;
        endcase
    end

    // Capture the granted miss for the check/alloc cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_nline_q       <= '0;
            req_tid_q         <= '0;
            req_sid_q         <= '0;
            req_word_q        <= '0;
            req_victim_way_q  <= '0;
            req_need_rsp_q    <= 1'b0;
            req_is_prefetch_q <= 1'b0;
            req_wback_q       <= 1'b0;
        end else if (grant_miss) begin
            req_nline_q       <= miss_nline_i;
            req_tid_q         <= miss_tid_i;
            req_sid_q         <= miss_sid_i;
            req_word_q        <= miss_word_i;
            req_victim_way_q  <= miss_victim_way_i;
            req_need_rsp_q    <= miss_need_rsp_i;
            req_is_prefetch_q <= miss_is_prefetch_i;
            req_wback_q       <= miss_wback_i;
        end
    end

    // One-cycle miss result pulse following the check cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_full_q  <= 1'b0;
            rsp_id_q    <= '0;
        end else begin
            rsp_valid_q <= in_check;
            rsp_hit_q   <= chk_hit;
            rsp_full_q  <= chk_full;
            rsp_id_q    <= do_alloc ? {mshr_alloc_way_i, req_nline_q[MshrSetWidth-1:0]} : '0;
        end
    end

    assign miss_rsp_valid_o = rsp_valid_q;
    assign miss_rsp_hit_o   = rsp_hit_q;
    assign miss_rsp_full_o  = rsp_full_q;
    assign miss_rsp_id_o    = rsp_id_q;

    // Pack the MSHR read data returned in the ack-read cycle.
    always_comb begin
        ack_info             = '0;
        ack_info.tid         = mshr_ack_tid_i;
        ack_info.sid         = mshr_ack_sid_i;
        ack_info.set         = mshr_ack_set_i;
        ack_info.way         = mshr_ack_way_i;
        ack_info.tag         = mshr_ack_tag_i;
        ack_info.word        = mshr_ack_word_i;
        ack_info.need_rsp    = mshr_ack_need_rsp_i;
        ack_info.is_prefetch = mshr_ack_is_prefetch_i;
        ack_info.wback       = mshr_ack_wback_i;
    end

    hpdcache_mshr_ctrl_infobuf #(
        .info_t (mshr_ack_info_t)
    ) i_infobuf (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (info_push),
        .push_data_i (ack_info),
        .valid_o     (info_valid_o),
        .ready_i     (info_ready_i),
        .data_o      (info_q)
    );

    assign info_tid_o         = info_q.tid;
    assign info_sid_o         = info_q.sid;
    assign info_set_o         = info_q.set;
    assign info_tag_o         = info_q.tag;
    assign info_way_o         = info_q.way;
    assign info_word_o        = info_q.word;
    assign info_need_rsp_o    = info_q.need_rsp;
    assign info_is_prefetch_o = info_q.is_prefetch;
    assign info_wback_o       = info_q.wback;

`ifdef HPDCACHE_MSHR_CTRL_PERF_EN
    logic [3:0]  perf_evt;
    logic [31:0] perf_cnt_q [4];

    assign perf_evt = {grant_ack, do_alloc, chk_full, chk_hit};

    // Saturating event counters: hit, full, alloc, ack.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 4; i++) begin
                perf_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (perf_evt[i] && (perf_cnt_q[i] != '1)) begin
                    perf_cnt_q[i] <= perf_cnt_q[i] + 32'd1;
                end
            end
        end
    end

    assign perf_hit_o   = perf_cnt_q[0];
    assign perf_full_o  = perf_cnt_q[1];
    assign perf_alloc_o = perf_cnt_q[2];
    assign perf_ack_o   = perf_cnt_q[3];
`else
    // Event counters are not built in this configuration.
`endif

endmodule
